rv32i_inst_encoder: RTL and testbench
=====================================

// Module: rv32i_inst_encoder
// PURPOSE
//  Program loader/assembler: the encode side of the RV32I control decoder. Accepts instruction requests
//  (op select + rd/rs1/rs2/imm) over valid/ready, packs legal RV32I words and buffers them in a FIFO.
//  Writes the words to sequential word addresses of the instruction memory.
//  Sits between the testbench/boot stimulus and the IM write port.
// PARAMETERS
//  ADDR_W      10  IM word-address width; addresses wrap modulo 2^ADDR_W
//  FIFO_DEPTH  4   encoded-word buffer depth (power of 2, >=2)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  start      in   1       pulse: begin a load session at base_addr (honoured only in IDLE)
//  base_addr  in   ADDR_W  first IM word address of the session
//  in_valid   in   1       request valid
//  in_ready   out  1       request accepted on the edge where in_valid&in_ready
//  in_op      in   5       ENC_OP select (see package)
//  in_rd      in   5       destination register
//  in_rs1     in   5       source 1
//  in_rs2     in   5       source 2
//  in_imm     in   32      immediate: sign value; U-type uses imm[31:12]; shifts use imm[4:0]
//  in_last    in   1       marks the final request of the session
//  im_we      out  1       IM write strobe
//  im_addr    out  ADDR_W  IM word address
//  im_wdata   out  32      encoded instruction
//  im_ready   in   1       IM accepts the write on the edge where im_we&im_ready
//  busy       out  1       state != IDLE
//  done       out  1       one-cycle pulse when the session completes
//  err        out  1       sticky: illegal in_op seen this session; cleared by the next accepted start
//  count      out  ADDR_W+1 words written this session; saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE. Reset mid-session aborts it: no further im_we, no done.
//  FSM: IDLE -start-> LOAD (addr<=base_addr, count<=0, err<=0).
//       LOAD -accept with in_last-> DRAIN. DRAIN -FIFO empty & no write pending-> DONE.
//       DONE -> IDLE (done=1 for exactly this cycle).
//  start is ignored outside IDLE. in_valid is ignored outside LOAD.
//  in_ready = (state==LOAD) & !fifo_full. Pop in the same cycle does not raise ready (no bypass).
//  Encode is combinational. The word is pushed at the accept edge. im_we is asserted from the next cycle
//   when the FIFO was empty: one-cycle latency, throughput 1 word/cycle.
//  im_we = !fifo_empty. im_addr/im_wdata come from the FIFO head and are held stable while im_we&!im_ready.
//  On im_we&im_ready: pop, addr<=addr+1 (wraps), count<=count+1 (saturating).
//  Illegal in_op (>=24): accepted (handshake completes), nothing pushed, err<=1. If in_last is set it still ends LOAD.
//  Field packing (bit order MSB..LSB):
//   R  {f7,rs2,rs1,f3,rd,op}
//   I  {imm[11:0],rs1,f3,rd,op}
//   Ishift {f7,imm[4:0],rs1,f3,rd,op}
//   S  {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   B  {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; imm[0] is ignored
//   J  {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//   U  {imm[31:12],rd,op}
//  Unused register fields of each format are not encoded. Immediate bits above each format's range are discarded.
//  ENC_OP codes:
//   0-9   add sub or and xor sll srl sra slt sltu
//   10-18 addi andi ori xori slti sltiu slli srli srai
//   19-23 lw sw beq jal lui
// STRUCTURE
//  rv_enc_pkg (shared): OPC_* 7-bit opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 0110111),
//   F3_*/F7_* constants, ENC_OP_* codes, FSM state encodings.
//  Sub-module rv_enc_fifo: synchronous FIFO, 32-bit data, FIFO_DEPTH entries, full/empty flags.
//   Registered head output; simultaneous push+pop allowed when not empty.
// TESTING
//  1 start base=0x010; add rd3 rs1 1 rs2 2 (last) -> im_we@0x010 data 0x002081B3; count=1; done pulse; busy=0.
//  2 addi rd5,rs1 0,imm -1 -> 0xFFF00293; srai rd4,rs1 3,imm 2 -> 0x4021D213;
//    lui rd5,imm 0x12345000 -> 0x123452B7.
//  3 sw rs2 2,rs1 1,imm 8 -> 0x0020A423; beq rs1 1,rs2 2,imm -4 -> 0xFE208EE3;
//    jal rd1,imm 8 -> 0x008000EF. Addresses are consecutive.
//  4 Hold im_ready=0 for 10 cycles, stream 6 requests -> in_ready drops after FIFO_DEPTH pushes.
//    im_addr/im_wdata stable; all 6 words written in order once im_ready=1.
//  5 base=0x3FF, 2 requests -> writes at 0x3FF then 0x000; count=2. in_op=25 mid-stream -> err=1, no write.
//    Next start clears err.
//  6 rst asserted in DRAIN with 3 words queued -> no im_we after reset edge, done never pulses, count=0.
//    start in LOAD -> ignored.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// ============================================================================
//  Module      : rv_enc_pkg
//  Description : Shared RV32I encoding constants, request op codes, encoder
//                FSM states and the combinational instruction packer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_enc_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [4:0] ENC_OP_ADD   = 5'd0;
    localparam logic [4:0] ENC_OP_SUB   = 5'd1;
    localparam logic [4:0] ENC_OP_OR    = 5'd2;
    localparam logic [4:0] ENC_OP_AND   = 5'd3;
    localparam logic [4:0] ENC_OP_XOR   = 5'd4;
    localparam logic [4:0] ENC_OP_SLL   = 5'd5;
    localparam logic [4:0] ENC_OP_SRL   = 5'd6;
    localparam logic [4:0] ENC_OP_SRA   = 5'd7;
    localparam logic [4:0] ENC_OP_SLT   = 5'd8;
    localparam logic [4:0] ENC_OP_SLTU  = 5'd9;
    localparam logic [4:0] ENC_OP_ADDI  = 5'd10;
    localparam logic [4:0] ENC_OP_ANDI  = 5'd11;
    localparam logic [4:0] ENC_OP_ORI   = 5'd12;
    localparam logic [4:0] ENC_OP_XORI  = 5'd13;
    localparam logic [4:0] ENC_OP_SLTI  = 5'd14;
    localparam logic [4:0] ENC_OP_SLTIU = 5'd15;
    localparam logic [4:0] ENC_OP_SLLI  = 5'd16;
    localparam logic [4:0] ENC_OP_SRLI  = 5'd17;
    localparam logic [4:0] ENC_OP_SRAI  = 5'd18;
    localparam logic [4:0] ENC_OP_LW    = 5'd19;
    localparam logic [4:0] ENC_OP_SW    = 5'd20;
    localparam logic [4:0] ENC_OP_BEQ   = 5'd21;
    localparam logic [4:0] ENC_OP_JAL   = 5'd22;
    localparam logic [4:0] ENC_OP_LUI   = 5'd23;
    localparam logic [4:0] ENC_OP_NUM   = 5'd24;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_J, FMT_U} fmt_t;

    // Codes at or above ENC_OP_NUM yield zero; callers must not push them.
    function automatic logic [31:0] enc_word(input logic [4:0] op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        fmt_t       fmt;
        logic [31:0] w;
        opc = OPC_OP;
        f3  = F3_ADD;
        f7  = F7_BASE;
        fmt = FMT_R;
        w   = '0;
        case (op)
            ENC_OP_ADD:   f3 = F3_ADD;
            ENC_OP_SUB:   f7 = F7_ALT;
            ENC_OP_OR:    f3 = F3_OR;
            ENC_OP_AND:   f3 = F3_AND;
            ENC_OP_XOR:   f3 = F3_XOR;
            ENC_OP_SLL:   f3 = F3_SLL;
            ENC_OP_SRL:   f3 = F3_SR;
            ENC_OP_SRA:   begin f3 = F3_SR; f7 = F7_ALT; end
            ENC_OP_SLT:   f3 = F3_SLT;
            ENC_OP_SLTU:  f3 = F3_SLTU;
            ENC_OP_ADDI:  begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_ADD; end
            ENC_OP_ANDI:  begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_AND; end
            ENC_OP_ORI:   begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_OR; end
            ENC_OP_XORI:  begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_XOR; end
            ENC_OP_SLTI:  begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_SLT; end
            ENC_OP_SLTIU: begin fmt = FMT_I; opc = OPC_OPIMM; f3 = F3_SLTU; end
            ENC_OP_SLLI:  begin fmt = FMT_ISH; opc = OPC_OPIMM; f3 = F3_SLL; end
            ENC_OP_SRLI:  begin fmt = FMT_ISH; opc = OPC_OPIMM; f3 = F3_SR; end
            ENC_OP_SRAI:  begin fmt = FMT_ISH; opc = OPC_OPIMM; f3 = F3_SR; f7 = F7_ALT; end
            ENC_OP_LW:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_LW; end
            ENC_OP_SW:    begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_SW; end
            ENC_OP_BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
            ENC_OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
            ENC_OP_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
            default:      opc = 7'b0000000;
        endcase
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, opc};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, opc};
            FMT_ISH: w = {f7, imm[4:0], rs1, f3, rd, opc};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            FMT_U:   w = {imm[31:12], rd, opc};
            default: w = '0;
        endcase
        if (op >= ENC_OP_NUM) begin
            w = '0;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv_enc_fifo.sv
// ============================================================================
//  Module      : rv_enc_fifo
//  Description : Synchronous 32-bit FIFO holding encoded words for the IM port.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv_enc_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [31:0] data_i,
    input  logic        pop_i,
    output logic [31:0] head_o,
    output logic        full_o,
    output logic        empty_o
);
    import rv_enc_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE = 1;

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        w_push;
    logic        w_pop;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv32i_inst_encoder.sv
// ============================================================================
//  Module      : rv32i_inst_encoder
//  Description : Encodes RV32I instruction requests and streams the words into
//                consecutive instruction-memory addresses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32i_inst_encoder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    input  logic              im_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);
    import rv_enc_pkg::*;

    localparam logic [ADDR_W-1:0] C_ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   C_CNT_ONE  = 1;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;

    logic              w_full;
    logic              w_empty;
    logic              w_legal;
    logic              w_accept;
    logic              w_pop;
    logic [31:0]       w_word;
    logic [31:0]       w_head;

    assign w_legal  = (in_op < ENC_OP_NUM);
    assign w_word   = enc_word(in_op, in_rd, in_rs1, in_rs2, in_imm);
    assign in_ready = (state_q == ST_LOAD) && !w_full;
    assign w_accept = in_valid && in_ready;
    assign im_we    = !w_empty;
    assign w_pop    = im_we && im_ready;

    assign im_addr  = addr_q;
    assign im_wdata = w_empty ? 32'd0 : w_head;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;
    assign count    = count_q;

    rv_enc_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_accept && w_legal),
        .data_i  (w_word),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (w_accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (w_empty) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                addr_q  <= base_addr;
                count_q <= '0;
                err_q   <= 1'b0;
            end else begin
                if (w_pop) begin
                    addr_q <= addr_q + C_ADDR_ONE;
                    if (count_q != '1) begin
                        count_q <= count_q + C_CNT_ONE;
                    end
                end
                if (w_accept && !w_legal) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_inst_encoder.sv
// ============================================================================
//  Module      : tb_rv32i_inst_encoder
//  Description : Directed self-checking bench for rv32i_inst_encoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv32i_inst_encoder;

    localparam int ADDR_W     = 10;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              im_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];

    rv32i_inst_encoder #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .im_ready  (im_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we && im_ready) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] b);
        start = 1'b1;
        base_addr = b;
        step(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        bit acc = 0;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_last = last;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = 1;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_accept: accepted=0 required=1 (op %0d)", op);
        end
    endtask

    task automatic wait_done(input string name);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_done: done_seen=0 required=1", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_op = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0; im_ready = 1'b0;
        step(3);
        @(negedge clk);
        checks++;
        if ({im_we, busy, done, err, in_ready} !== 5'b0 || count !== '0 || im_addr !== '0
            || im_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: we/busy/done/err/rdy=%b count=%0d addr=%h data=%h required all 0",
                     {im_we, busy, done, err, in_ready}, count, im_addr, im_wdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_single();
        wa.delete(); wd.delete();
        im_ready = 1'b1;
        start_session(10'h010);
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (im_we !== 1'b1 || im_addr !== 10'h010) begin
            errors++;
            $display("FAIL single_latency: im_we=%b addr=%h required 1 010", im_we, im_addr);
        end
        wait_done("single");
        checks++;
        if (wa.size() != 1 || wa[0] !== 10'h010 || wd[0] !== 32'h002081B3) begin
            errors++;
            $display("FAIL single_write: n=%0d addr=%h data=%h required 1 010 002081b3",
                     wa.size(), wa.size() > 0 ? wa[0] : 10'h0, wd.size() > 0 ? wd[0] : 32'h0);
        end
        checks++;
        if (count !== 11'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_status: count=%0d busy=%b required 1 0", count, busy);
        end
    endtask

    task automatic test_encode();
        logic [31:0] exp_d[3];
        exp_d[0] = 32'hFFF00293; exp_d[1] = 32'h4021D213; exp_d[2] = 32'h123452B7;
        wa.delete(); wd.delete();
        start_session(10'h020);
        send(5'd10, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
        send(5'd18, 5'd4, 5'd3, 5'd0, 32'd2, 1'b0);
        send(5'd23, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        wait_done("encode");
        checks++;
        if (wa.size() != 3) begin
            errors++;
            $display("FAIL encode_count: writes=%0d required 3", wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wd[i] !== exp_d[i] || wa[i] !== 10'h020 + 10'(i)) begin
                    errors++;
                    $display("FAIL encode_word%0d: addr=%h data=%h required %h %h",
                             i, wa[i], wd[i], 10'h020 + 10'(i), exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_store_branch_jump();
        logic [31:0] exp_d[3];
        exp_d[0] = 32'h0020A423; exp_d[1] = 32'hFE208EE3; exp_d[2] = 32'h008000EF;
        wa.delete(); wd.delete();
        start_session(10'h100);
        send(5'd20, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        send(5'd21, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0);
        send(5'd22, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1);
        wait_done("sbj");
        checks++;
        if (wa.size() != 3) begin
            errors++;
            $display("FAIL sbj_count: writes=%0d required 3", wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wd[i] !== exp_d[i] || wa[i] !== 10'h100 + 10'(i)) begin
                    errors++;
                    $display("FAIL sbj_word%0d: addr=%h data=%h required %h %h",
                             i, wa[i], wd[i], 10'h100 + 10'(i), exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit bad = 0;
        wa.delete(); wd.delete();
        im_ready = 1'b0;
        start_session(10'h040);
        for (int k = 1; k <= 4; k++) send(5'd0, 5'(k), 5'd1, 5'd2, 32'd0, 1'b0);
        in_valid = 1'b1; in_op = 5'd0; in_rd = 5'd5; in_rs1 = 5'd1; in_rs2 = 5'd2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || im_we !== 1'b1 || im_addr !== 10'h040
                || im_wdata !== 32'h002080B3) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: rdy=%b we=%b addr=%h data=%h required 0 1 040 002080b3",
                     in_ready, im_we, im_addr, im_wdata);
        end
        @(posedge clk);
        #1;
        im_ready = 1'b1;
        send(5'd0, 5'd5, 5'd1, 5'd2, 32'd0, 1'b0);
        send(5'd0, 5'd6, 5'd1, 5'd2, 32'd0, 1'b1);
        wait_done("bp");
        checks++;
        if (wa.size() != 6 || count !== 11'd6) begin
            errors++;
            $display("FAIL bp_count: writes=%0d count=%0d required 6 6", wa.size(), count);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wa[i] !== 10'h040 + 10'(i) || wd[i] !== (32'h00208033 | (32'(i + 1) << 7))) begin
                    errors++;
                    $display("FAIL bp_word%0d: addr=%h data=%h required %h %h", i, wa[i], wd[i],
                             10'h040 + 10'(i), 32'h00208033 | (32'(i + 1) << 7));
                end
            end
        end
    endtask

    task automatic test_wrap_illegal();
        wa.delete(); wd.delete();
        im_ready = 1'b1;
        start_session(10'h3FF);
        send(5'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0);
        send(5'd25, 5'd7, 5'd7, 5'd7, 32'd0, 1'b0);
        send(5'd0, 5'd2, 5'd1, 5'd2, 32'd0, 1'b1);
        wait_done("wrap");
        checks++;
        if (wa.size() != 2 || wa[0] !== 10'h3FF || wa[1] !== 10'h000
            || wd[0] !== 32'h002080B3 || wd[1] !== 32'h00208133) begin
            errors++;
            $display("FAIL wrap_writes: n=%0d required 2 writes 3ff/002080b3 000/00208133", wa.size());
        end
        checks++;
        if (count !== 11'd2 || err !== 1'b1) begin
            errors++;
            $display("FAIL wrap_status: count=%0d err=%b required 2 1", count, err);
        end
        wa.delete(); wd.delete();
        start_session(10'h005);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
        send(5'd31, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);
        wait_done("illegal_last");
        checks++;
        if (wa.size() != 0 || err !== 1'b1 || count !== 11'd0) begin
            errors++;
            $display("FAIL illegal_last: writes=%0d err=%b count=%0d required 0 1 0",
                     wa.size(), err, count);
        end
    endtask

    task automatic test_start_ignored();
        wa.delete(); wd.delete();
        im_ready = 1'b1;
        start_session(10'h060);
        send(5'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0);
        start_session(10'h200);
        send(5'd0, 5'd2, 5'd1, 5'd2, 32'd0, 1'b1);
        wait_done("start_ign");
        checks++;
        if (wa.size() != 2 || wa[0] !== 10'h060 || wa[1] !== 10'h061) begin
            errors++;
            $display("FAIL start_ignored: n=%0d first=%h required 2 writes at 060 061",
                     wa.size(), wa.size() > 0 ? wa[0] : 10'h0);
        end
    endtask

    task automatic test_reset_midsession();
        int n_wr;
        int n_done;
        im_ready = 1'b0;
        start_session(10'h050);
        send(5'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0);
        send(5'd0, 5'd2, 5'd1, 5'd2, 32'd0, 1'b0);
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || im_we !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_state: busy=%b we=%b rdy=%b required 1 1 0", busy, im_we, in_ready);
        end
        n_wr = wa.size();
        n_done = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        im_ready = 1'b1;
        step(10);
        checks++;
        if (wa.size() != n_wr || done_cnt != n_done || count !== '0 || busy !== 1'b0
            || im_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: new_writes=%0d new_done=%0d count=%0d busy=%b we=%b required all 0",
                     wa.size() - n_wr, done_cnt - n_done, count, busy, im_we);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_encode();
        test_store_branch_jump();
        test_backpressure();
        test_wrap_illegal();
        test_start_ignored();
        test_reset_midsession();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim_time=%0t limit reached", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
